add_num_job_sched: RTL

// - Sequences the add-two-numbers datapath over CCI-P channels c0 (reads) and c1 (writes).
// - Software queues jobs, each a source line address and a destination line address.
// - Per job: one c0 read of the source line, an add of two operand fields, one c1 write of the sum.
// - Completes each job on its write ack.
// - Sits between the AFU CSR decode (job pushes) and the host_ccip sTx/sRx request/response paths.

---
 rtl/add_num_job_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/add_num_job_sched.sv
// Job scheduler for the add-two-numbers AFU: queues (src,dst) jobs, reads a line on c0, writes A+B on c1.
// Optional response timeout is enabled with `define ADD_NUM_SCHED_TIMEOUT_EN.
module add_num_job_sched #(
  parameter int JOB_FIFO_DEPTH = 4,
  parameter int OP_W           = 8,
  parameter int OP_A_LSB       = 8,
  parameter int OP_B_LSB       = 16,
  parameter int RSP_TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [41:0]  job_src_addr,
  input  logic [41:0]  job_dst_addr,
  input  logic         c0_almfull,
  output logic         rd_req_valid,
  output logic [41:0]  rd_req_addr,
  output logic [15:0]  rd_req_mdata,
  input  logic         rd_rsp_valid,
  input  logic [15:0]  rd_rsp_mdata,
  input  logic [511:0] rd_rsp_data,
  input  logic         c1_almfull,
  output logic         wr_req_valid,
  output logic [41:0]  wr_req_addr,
  output logic [511:0] wr_req_data,
  output logic [15:0]  wr_req_mdata,
  input  logic         wr_rsp_valid,
  input  logic [15:0]  wr_rsp_mdata,
  output logic         busy,
  output logic [31:0]  done_count,
  output logic         err
);

  localparam int PW = $clog2(JOB_FIFO_DEPTH);

  typedef struct packed {
    logic [41:0] src;
    logic [41:0] dst;
  } job_t;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

  job_t          mem_q [JOB_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full, empty, push, pop, timeout;

  state_e         state_q;
  logic [41:0]    src_q, dst_q;
  logic [OP_W-1:0] a_q, b_q;
  logic [OP_W:0]  sum;
  logic [15:0]    tag_q;
  logic           tag_vld_q;
  logic           rd_req_valid_q, wr_req_valid_q;
  logic [41:0]    rd_req_addr_q, wr_req_addr_q;
  logic [15:0]    rd_req_mdata_q, wr_req_mdata_q;
  logic [511:0]   wr_req_data_q;
  logic [31:0]    done_q;
  logic           err_q;
  logic           unused_ok;

  assign full      = (cnt_q == (PW+1)'(JOB_FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign push      = job_valid && !full;
  assign pop       = (state_q == IDLE) && !empty;
  assign job_ready = !full;
  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign unused_ok = ^{rd_rsp_data, 32'(RSP_TIMEOUT)};

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {job_src_addr, job_dst_addr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

`ifdef ADD_NUM_SCHED_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        in_wait;
  assign in_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  // Restarts on every entry to a wait state since the request states clear it.
  always_ff @(posedge clk) begin
    if (reset || !in_wait) wait_cnt_q <= '0;
    else                   wait_cnt_q <= wait_cnt_q + 16'd1;
  end
  assign timeout = in_wait && (wait_cnt_q == 16'(RSP_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      tag_q          <= '0;
      tag_vld_q      <= 1'b0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      rd_req_mdata_q <= '0;
      wr_req_valid_q <= 1'b0;
      wr_req_addr_q  <= '0;
      wr_req_data_q  <= '0;
      wr_req_mdata_q <= '0;
      done_q         <= '0;
      err_q          <= 1'b0;
    end else begin
      rd_req_valid_q <= 1'b0;
      wr_req_valid_q <= 1'b0;
      // Stray responses only count once a job has established a live tag since reset.
      if (tag_vld_q && rd_rsp_valid && state_q != RD_WAIT) err_q <= 1'b1;
      if (tag_vld_q && wr_rsp_valid && state_q != WR_WAIT) err_q <= 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          src_q     <= mem_q[rd_ptr_q].src;
          dst_q     <= mem_q[rd_ptr_q].dst;
          tag_vld_q <= 1'b1;
          state_q   <= RD_REQ;
        end
        RD_REQ: if (!c0_almfull) begin
          rd_req_valid_q <= 1'b1;
          rd_req_addr_q  <= src_q;
          rd_req_mdata_q <= tag_q;
          state_q        <= RD_WAIT;
        end
        RD_WAIT: begin
          if (rd_rsp_valid && rd_rsp_mdata == tag_q) begin
            a_q     <= rd_rsp_data[OP_A_LSB +: OP_W];
            b_q     <= rd_rsp_data[OP_B_LSB +: OP_W];
            state_q <= WR_REQ;
          end else begin
            if (rd_rsp_valid) err_q <= 1'b1;
            if (timeout) begin
              err_q   <= 1'b1;
              tag_q   <= tag_q + 16'd1;
              state_q <= IDLE;
            end
          end
        end
        WR_REQ: if (!c1_almfull) begin
          wr_req_valid_q <= 1'b1;
          wr_req_addr_q  <= dst_q;
          wr_req_data_q  <= {{(512-OP_W-1){1'b0}}, sum};
          wr_req_mdata_q <= tag_q;
          state_q        <= WR_WAIT;
        end
        WR_WAIT: begin
          if (wr_rsp_valid && wr_rsp_mdata == tag_q) begin
            done_q  <= done_q + 32'd1;
            tag_q   <= tag_q + 16'd1;
            state_q <= IDLE;
          end else begin
            if (wr_rsp_valid) err_q <= 1'b1;
            if (timeout) begin
              err_q   <= 1'b1;
              tag_q   <= tag_q + 16'd1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_req_valid = rd_req_valid_q;
  assign rd_req_addr  = rd_req_addr_q;
  assign rd_req_mdata = rd_req_mdata_q;
  assign wr_req_valid = wr_req_valid_q;
  assign wr_req_addr  = wr_req_addr_q;
  assign wr_req_data  = wr_req_data_q;
  assign wr_req_mdata = wr_req_mdata_q;
  assign busy         = (state_q != IDLE) || !empty;
  assign done_count   = done_q;
  assign err          = err_q;

endmodule
